// File: rtl/ext_mem_reader_cmd_gen.sv
// Read-command to address-beat generator: a FWFT command FIFO feeds an IDLE/LOAD/BURST FSM
// that emits one strobed beat per DATA_W word. EXT_MEM_READER_TAG_EN carries TAG through to beat_tag.
module ext_mem_reader_cmd_gen #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int CMD_FIFO_AW = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [71:0]            cmd_data,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  output logic [ADDR_W-1:0]      beat_addr,
  output logic [DATA_W/8-1:0]    beat_strb,
  output logic                   beat_last,
  output logic [3:0]             beat_tag,
  output logic                   beat_valid,
  input  logic                   beat_ready,
  output logic                   err_zero_len,
  output logic                   busy,
  output logic [CMD_FIFO_AW:0]   cmd_fifo_level
);

  localparam int BYTES = DATA_W / 8;
  localparam int LB    = $clog2(BYTES);
  localparam int DEPTH = 1 << CMD_FIFO_AW;
`ifdef EXT_MEM_READER_TAG_EN
  localparam int FIFO_W = 72;
`else
  localparam int FIFO_W = 68;
`endif

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BURST} state_e;

  logic [FIFO_W-1:0]    mem_q [DEPTH];
  logic [CMD_FIFO_AW:0] wr_ptr_q, rd_ptr_q, level;
  logic [FIFO_W-1:0]    fifo_in, head;
  logic                 full, empty, push, pop;

  state_e               state_q;
  logic [22:0]          btt_q;
  logic [ADDR_W-1:0]    saddr_q;
  logic [23:0]          rem_q;
  logic [BYTES-1:0]     last_mask_q;
  logic [ADDR_W-1:0]    beat_addr_q;
  logic [BYTES-1:0]     beat_strb_q;
  logic                 beat_last_q, beat_valid_q, err_q;

  logic [23:0]          off24, nbeats, lidx;
  logic [BYTES-1:0]     first_mask, last_mask;
  logic [ADDR_W-1:0]    aligned;
  logic                 unused_head;

  // Entry is the command word minus the TAG field when tagging is off.
`ifdef EXT_MEM_READER_TAG_EN
  assign fifo_in = cmd_data;
`else
  assign fifo_in = {cmd_data[71:68], cmd_data[63:0]};
  logic unused_cmd_tag;
  assign unused_cmd_tag = ^cmd_data[67:64];
`endif

  assign level          = wr_ptr_q - rd_ptr_q;
  assign full           = (level == (CMD_FIFO_AW+1)'(DEPTH));
  assign empty          = (level == '0);
  assign cmd_ready      = ~full;
  assign push           = cmd_valid & ~full;
  assign pop            = (state_q == S_IDLE) & ~empty;
  assign head           = mem_q[rd_ptr_q[CMD_FIFO_AW-1:0]];
  assign unused_head    = ^{head[31:23], head[63:32], head[FIFO_W-1:64]};
  assign cmd_fifo_level = level;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[CMD_FIFO_AW-1:0]] <= fifo_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_comb begin
    off24      = 24'(saddr_q & ADDR_W'(BYTES - 1));
    nbeats     = (off24 + {1'b0, btt_q} + 24'(BYTES - 1)) >> LB;
    lidx       = (off24 + {1'b0, btt_q} - 24'd1) & 24'(BYTES - 1);
    first_mask = {BYTES{1'b1}} << off24;
    last_mask  = {BYTES{1'b1}} >> (24'(BYTES - 1) - lidx);
    aligned    = saddr_q & ~ADDR_W'(BYTES - 1);
  end

`ifdef EXT_MEM_READER_TAG_EN
  logic [3:0] tag_q, beat_tag_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q      <= '0;
      beat_tag_q <= '0;
    end else begin
      if (pop) tag_q <= head[67:64];
      if (state_q == S_LOAD && btt_q != '0) beat_tag_q <= tag_q;
    end
  end
  assign beat_tag = beat_tag_q;
`else
  assign beat_tag = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      btt_q        <= '0;
      saddr_q      <= '0;
      rem_q        <= '0;
      last_mask_q  <= '0;
      beat_addr_q  <= '0;
      beat_strb_q  <= '0;
      beat_last_q  <= 1'b0;
      beat_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!empty) begin
            btt_q   <= head[22:0];
            saddr_q <= head[32 +: ADDR_W];
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (btt_q == '0) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            beat_valid_q <= 1'b1;
            beat_addr_q  <= aligned;
            rem_q        <= nbeats;
            last_mask_q  <= last_mask;
            beat_strb_q  <= (nbeats == 24'd1) ? (first_mask & last_mask) : first_mask;
            beat_last_q  <= (nbeats == 24'd1);
            state_q      <= S_BURST;
          end
        end
        S_BURST: begin
          if (beat_valid_q && beat_ready) begin
            if (beat_last_q) begin
              beat_valid_q <= 1'b0;
              state_q      <= S_IDLE;
            end else begin
              beat_addr_q <= beat_addr_q + ADDR_W'(BYTES);
              rem_q       <= rem_q - 24'd1;
              beat_strb_q <= (rem_q == 24'd2) ? last_mask_q : '1;
              beat_last_q <= (rem_q == 24'd2);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign beat_addr    = beat_addr_q;
  assign beat_strb    = beat_strb_q;
  assign beat_last    = beat_last_q;
  assign beat_valid   = beat_valid_q;
  assign err_zero_len = err_q;
  assign busy         = (state_q != S_IDLE) | ~empty;

endmodule

// File: tb/tb_ext_mem_reader_cmd_gen.sv
// Directed bench for ext_mem_reader_cmd_gen (DATA_W=32, ADDR_W=32, 8-entry FIFO).
module tb_ext_mem_reader_cmd_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [71:0] cmd_data;
  logic        cmd_valid, cmd_ready;
  logic [31:0] beat_addr;
  logic [3:0]  beat_strb, beat_tag, cmd_fifo_level;
  logic        beat_last, beat_valid, beat_ready, err_zero_len, busy;

  ext_mem_reader_cmd_gen #(.DATA_W(32), .ADDR_W(32), .CMD_FIFO_AW(3)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .beat_addr(beat_addr), .beat_strb(beat_strb), .beat_last(beat_last), .beat_tag(beat_tag),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .err_zero_len(err_zero_len), .busy(busy),
    .cmd_fifo_level(cmd_fifo_level)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] sa;
    logic [22:0] btt;
    logic [3:0]  tag;
    int          n;
    logic [31:0] a0;
    logic [3:0]  s0;
    logic [3:0]  sl;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] mk(input logic [31:0] sa, input logic [22:0] btt, input logic [3:0] tag);
    logic [71:0] w;
    w        = '0;
    w[22:0]  = btt;
    w[31:23] = 9'h155;
    w[63:32] = sa;
    w[67:64] = tag;
    w[71:68] = 4'hA;
    return w;
  endfunction

  function automatic logic [3:0] etag(input logic [3:0] t);
`ifdef EXT_MEM_READER_TAG_EN
    return t;
`else
    return (t & 4'h0);
`endif
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  acc, w;
    logic saw;
    logic [3:0] es;

    vecs[0] = '{32'h0000_1000, 23'd16, 4'd1, 4, 32'h0000_1000, 4'hF, 4'hF};
    vecs[1] = '{32'h0000_1003, 23'd6,  4'd2, 3, 32'h0000_1000, 4'h8, 4'h1};
    vecs[2] = '{32'h0000_2001, 23'd2,  4'd3, 1, 32'h0000_2000, 4'h6, 4'h6};
    vecs[3] = '{32'hFFFF_FFF8, 23'd16, 4'd4, 4, 32'hFFFF_FFF8, 4'hF, 4'hF};
    vecs[4] = '{32'h0000_0040, 23'd4,  4'd9, 1, 32'h0000_0040, 4'hF, 4'hF};
    vecs[5] = '{32'h0000_1002, 23'd7,  4'd7, 3, 32'h0000_1000, 4'hC, 4'h1};
    vecs[6] = '{32'h0000_0005, 23'd3,  4'hE, 1, 32'h0000_0004, 4'hE, 4'hE};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_data = '0; beat_ready = 1'b1;
    repeat (2) step();
    chk("rst_valid", beat_valid, 0);
    chk("rst_addr", beat_addr, 0);
    chk("rst_strb", beat_strb, 0);
    chk("rst_last", beat_last, 0);
    chk("rst_tag", beat_tag, 0);
    chk("rst_err", err_zero_len, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", cmd_fifo_level, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    rst_n = 1'b1;
    step();

    // Table of single commands with beat_ready held high.
    for (int v = 0; v < 7; v++) begin
      cmd_data = mk(vecs[v].sa, vecs[v].btt, vecs[v].tag);
      cmd_valid = 1'b1;
      chk("cmd_ready", cmd_ready, 1);
      step();
      cmd_valid = 1'b0;
      chk("lat_k", beat_valid, 0);
      chk("busy_k", busy, 1);
      step();
      chk("lat_k1", beat_valid, 0);
      step();
      for (int b = 0; b < vecs[v].n; b++) begin
        es = (b == 0) ? vecs[v].s0 : (b == vecs[v].n - 1) ? vecs[v].sl : 4'hF;
        chk("tv_valid", beat_valid, 1);
        chk("tv_addr", beat_addr, vecs[v].a0 + 32'(4 * b));
        chk("tv_strb", beat_strb, es);
        chk("tv_last", beat_last, (b == vecs[v].n - 1) ? 1 : 0);
        chk("tv_tag", beat_tag, etag(vecs[v].tag));
        chk("tv_err", err_zero_len, 0);
        step();
      end
      chk("tv_done_valid", beat_valid, 0);
      chk("tv_done_busy", busy, 0);
    end

    // Zero-length command followed by a real one.
    cmd_data = mk(32'h0000_0000, 23'd0, 4'd5); cmd_valid = 1'b1;
    step();
    cmd_data = mk(32'h0000_0040, 23'd4, 4'd9);
    step();
    cmd_valid = 1'b0;
    chk("zl_err_k1", err_zero_len, 0);
    chk("zl_valid_k1", beat_valid, 0);
    step();
    chk("zl_err_k2", err_zero_len, 1);
    chk("zl_valid_k2", beat_valid, 0);
    step();
    chk("zl_err_k3", err_zero_len, 0);
    chk("zl_valid_k3", beat_valid, 0);
    step();
    chk("zl_valid", beat_valid, 1);
    chk("zl_addr", beat_addr, 32'h40);
    chk("zl_strb", beat_strb, 4'hF);
    chk("zl_last", beat_last, 1);
    chk("zl_tag", beat_tag, etag(4'd9));
    chk("zl_err_k4", err_zero_len, 0);
    step();
    chk("zl_done", beat_valid, 0);
    chk("zl_err_k5", err_zero_len, 0);

    // Backpressure: fill register + FIFO, then drain in order.
    beat_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      cmd_data = mk(32'h3000 + 32'(16 * i), 23'd4, 4'(i + 1));
      cmd_valid = 1'b1;
      if (cmd_ready) acc++;
      step();
    end
    cmd_valid = 1'b0;
    chk("bp_accepted", acc, 9);
    chk("bp_cmd_ready", cmd_ready, 0);
    chk("bp_level", cmd_fifo_level, 8);
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold_valid", beat_valid, 1);
      chk("bp_hold_addr", beat_addr, 32'h3000);
      chk("bp_hold_strb", beat_strb, 4'hF);
      chk("bp_hold_last", beat_last, 1);
      chk("bp_hold_tag", beat_tag, etag(4'd1));
      step();
    end
    chk("bp_level_hold", cmd_fifo_level, 8);
    beat_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      w = 0;
      while (!beat_valid && w < 10) begin
        step();
        w++;
      end
      chk("dr_valid", beat_valid, 1);
      chk("dr_addr", beat_addr, 32'h3000 + 32'(16 * i));
      chk("dr_tag", beat_tag, etag(4'(i + 1)));
      chk("dr_last", beat_last, 1);
      step();
    end
    repeat (3) step();
    chk("dr_level", cmd_fifo_level, 0);
    chk("dr_busy", busy, 0);

    // Reset during the second beat of a 4-beat command with 3 queued.
    cmd_data = mk(32'h1000, 23'd16, 4'd1); cmd_valid = 1'b1;
    step();
    cmd_data = mk(32'h5000, 23'd4, 4'd2);
    step();
    cmd_data = mk(32'h5010, 23'd4, 4'd3);
    step();
    chk("mr_beat1", beat_addr, 32'h1000);
    cmd_data = mk(32'h5020, 23'd4, 4'd4);
    step();
    cmd_valid = 1'b0;
    chk("mr_beat2", beat_addr, 32'h1004);
    chk("mr_queued", cmd_fifo_level, 3);
    rst_n = 1'b0;
    #1;
    chk("mr_valid", beat_valid, 0);
    chk("mr_addr", beat_addr, 0);
    chk("mr_strb", beat_strb, 0);
    chk("mr_last", beat_last, 0);
    chk("mr_tag", beat_tag, 0);
    chk("mr_err", err_zero_len, 0);
    chk("mr_busy", busy, 0);
    chk("mr_level", cmd_fifo_level, 0);
    step();
    rst_n = 1'b1;
    saw = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (beat_valid) saw = 1'b1;
    end
    chk("mr_no_beats", saw, 0);
    chk("mr_busy_after", busy, 0);
    cmd_data = mk(32'h7000, 23'd8, 4'd6); cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk("mr_new_valid", beat_valid, 1);
    chk("mr_new_addr", beat_addr, 32'h7000);
    chk("mr_new_last", beat_last, 0);
    step();
    chk("mr_new_addr2", beat_addr, 32'h7004);
    chk("mr_new_last2", beat_last, 1);
    step();
    chk("mr_new_done", beat_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ext_mem_reader_cmd_gen.md
# ext_mem_reader_cmd_gen

Parametrised command-to-beat address generator for the external-memory read path. Accepts 72-bit read commands (byte count BTT, start address SADDR, tag), buffers them in an internal synchronous FIFO, and emits one address beat per DATA_W-wide word with a full valid/ready handshake. Handles unaligned start addresses and byte counts through first- and last-beat byte strobes and a last flag. Sits between the command producer and the external-memory reader model or port.

## Interface

- DATA_W, 32: beat data width in bits; power of two, at least 8. BYTES = DATA_W/8.
- ADDR_W, 32: address width, at most 32; SADDR is truncated to its low ADDR_W bits.
- CMD_FIFO_AW, 3: log2 of command FIFO depth (default 8 entries).

- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_data  in  72  [22:0] BTT, [63:32] SADDR, [67:64] TAG; all other bits ignored.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  equals ~fifo_full (combinational).
- beat_addr  out  ADDR_W  beat address, aligned to BYTES.
- beat_strb  out  BYTES  valid-byte mask for the beat.
- beat_last  out  1  final beat of the command.
- beat_tag  out  4  TAG of the command in progress.
- beat_valid  out  1  beat payload valid.
- beat_ready  in  1  consumer accepts the beat.
- err_zero_len  out  1  one-cycle pulse when a BTT=0 command is discarded.
- busy  out  1  high when the FSM is not IDLE or the FIFO is not empty.
- cmd_fifo_level  out  CMD_FIFO_AW+1  FIFO occupancy.

## Operation

- FIFO:
  - Synchronous, first-word fall-through, depth 2^CMD_FIFO_AW.
  - Push when cmd_valid && cmd_ready.
  - Pop only from IDLE.
  - At full, a push in the same cycle as a pop is still refused, because cmd_ready depends only on full.
- FSM states: IDLE, LOAD, BURST.
- IDLE:
  - If the FIFO is not empty: latch the head into the command register, pop, and go to LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - off = SADDR mod BYTES.
  - nbeats = (off + BTT + BYTES - 1) / BYTES, computed in 24-bit arithmetic.
  - beat_addr = SADDR with its low log2(BYTES) bits cleared.
  - If BTT = 0: pulse err_zero_len and return to IDLE; no beat is emitted.
  - Otherwise: set beat_valid and go to BURST.
- BURST:
  - A beat handshake occurs when beat_valid && beat_ready.
  - On each handshake, decrement the remaining-beat count and add BYTES to beat_addr, modulo 2^ADDR_W.
  - On the handshake of the beat with beat_last high: clear beat_valid and go to IDLE.
- Strobes:
  - First beat: bits [BYTES-1:off] set.
  - Last beat: bits [(off+BTT-1) mod BYTES : 0] set.
  - Single-beat command: the AND of the two masks.
  - Middle beats: all ones.
- beat_last is high exactly when the remaining-beat count is 1.
- Payload stability: while beat_valid is high and beat_ready is low, beat_addr, beat_strb, beat_last and beat_tag hold their values.
- Reset:
  - Outputs: beat_valid=0, beat_addr=0, beat_strb=0, beat_last=0, beat_tag=0, err_zero_len=0, busy=0, cmd_fifo_level=0.
  - FSM returns to IDLE and the FIFO is emptied.
  - Reset asserted mid-burst drops the in-flight command and all queued commands.

## Timing

- Command accepted at edge k: FIFO non-empty after k, IDLE pops at k+1, LOAD asserts beat_valid at k+2. With beat_ready held high, beats then complete one per cycle.
- Last-beat handshake at edge m: the next queued command's first beat is valid after edge m+2.
- Throughput per command: nbeats + 2 cycles.
- err_zero_len is high for exactly the cycle following the LOAD edge.
- Queuing capacity: one command sits in the command register and 2^CMD_FIFO_AW sit in the FIFO.

## Configuration

- Macro: EXT_MEM_READER_TAG_EN.
- Defined: TAG is stored in the FIFO and command register and presented on beat_tag for every beat of its command.
- Undefined: the tag storage is not built and beat_tag is tied to 0. The FIFO width drops from 72 to 68 bits (the TAG field is not stored).

## Test plan

All scenarios use DATA_W=32 and ADDR_W=32.

- SADDR=0x1000, BTT=16, beat_ready=1 -> beats 0x1000, 0x1004, 0x1008, 0x100C; strb 0xF on each; beat_last on the 4th; first beat valid after edge k+2.
- SADDR=0x1003, BTT=6 -> 0x1000 strb 0x8; 0x1004 strb 0xF; 0x1008 strb 0x1 with last. Also SADDR=0x2001, BTT=2 -> a single beat 0x2000, strb 0x6, last.
- BTT=0 with TAG=5, followed by SADDR=0x40, BTT=4, TAG=9 -> one err_zero_len pulse and no beat for the first command; a single beat 0x40, strb 0xF, last, beat_tag=9 (0 without EXT_MEM_READER_TAG_EN).
- SADDR=0xFFFFFFF8, BTT=16 -> beats 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004; last on the 4th.
- beat_ready=0 held, then 12 commands offered back to back -> 9 accepted (1 in register, 8 in FIFO); cmd_ready low from then on with cmd_fifo_level=8; beat payload constant throughout; releasing beat_ready drains all 9 in order.
- rst_n pulsed low during the 2nd beat of a 4-beat command, with 3 commands queued -> all outputs at reset values immediately; busy=0; no beats after rst_n rises until a new command is accepted.
